// File: rtl/pipe_hazard_sched_if.sv
// Hazard-scheduler pipeline signal bundle: ID/EX hazard inputs and stall/flush control outputs.
// The master drives the pipeline-side inputs; the slave is the scheduler itself.
interface pipe_hazard_sched_if #(
    parameter int unsigned PERF_W = 16
);
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic              id_md_start;
    logic              ex_memread;
    logic              ex_regwrite;
    logic [4:0]        ex_rw;
    logic              branch_taken;
    logic              pc_en;
    logic              ifid_en;
    logic              ifid_flush;
    logic              idex_flush;
    logic              md_busy;
    logic              md_done;
    logic              protocol_err;
    logic [PERF_W-1:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_md_start,
               ex_memread, ex_regwrite, ex_rw, branch_taken,
        input  pc_en, ifid_en, ifid_flush, idex_flush, md_busy, md_done,
               protocol_err, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_md_start,
               ex_memread, ex_regwrite, ex_rw, branch_taken,
        output pc_en, ifid_en, ifid_flush, idex_flush, md_busy, md_done,
               protocol_err, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_sched.sv
// Hazard scheduler for the 5-stage pipeline: load-use stalls, mul/div EX occupancy and
// taken-branch squashes. Outputs are combinational from state and inputs.
module pipe_hazard_sched #(
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned CNT_W      = 3,
    parameter int unsigned PERF_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_sched_if.slave bus
);
    typedef enum logic {
        ST_RUN,
        ST_MD_WAIT
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              r_perr;
    logic [PERF_W-1:0] r_stall;
    logic              w_lu;
    logic              w_pc_en;

    assign w_lu = bus.ex_memread && bus.ex_regwrite && (bus.ex_rw != 5'd0) &&
                  ((bus.id_uses_rs && (bus.id_rs == bus.ex_rw)) ||
                   (bus.id_uses_rt && (bus.id_rt == bus.ex_rw)));

    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_pc_en        = 1'b1;
        bus.ifid_en    = 1'b1;
        bus.ifid_flush = 1'b0;
        bus.idex_flush = 1'b0;
        bus.md_busy    = 1'b0;
        bus.md_done    = 1'b0;
        if (rst) begin
            w_pc_en        = 1'b0;
            bus.ifid_en    = 1'b0;
            bus.ifid_flush = 1'b1;
            bus.idex_flush = 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (bus.branch_taken) begin
                        bus.ifid_flush = 1'b1;
                        bus.idex_flush = 1'b1;
                    end else if (w_lu) begin
                        w_pc_en        = 1'b0;
                        bus.ifid_en    = 1'b0;
                        bus.idex_flush = 1'b1;
                    end else if (bus.id_md_start) begin
                        w_state_nxt = ST_MD_WAIT;
                        w_count_nxt = CNT_W'(MD_LATENCY - 1);
                    end
                end
                ST_MD_WAIT: begin
                    w_pc_en        = 1'b0;
                    bus.ifid_en    = 1'b0;
                    bus.idex_flush = 1'b1;
                    bus.md_busy    = 1'b1;
                    w_count_nxt    = r_count - CNT_W'(1);
                    if (r_count == CNT_W'(1)) begin
                        bus.md_done = 1'b1;
                        w_state_nxt = ST_RUN;
                    end
                end
                default: w_state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_count <= '0;
            r_perr  <= 1'b0;
            r_stall <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            if ((r_state == ST_MD_WAIT) && bus.branch_taken) begin
                r_perr <= 1'b1;
            end
            if (!w_pc_en && (r_stall != '1)) begin
                r_stall <= r_stall + PERF_W'(1);
            end
        end
    end

    assign bus.pc_en        = w_pc_en;
    assign bus.protocol_err = r_perr;
    assign bus.stall_cycles = r_stall;
endmodule

// File: tb/tb_pipe_hazard_sched.sv
// Directed bench for pipe_hazard_sched: an abstract stall/countdown model checked every
// cycle, plus literal expectations on the directed scenarios.
module tb_pipe_hazard_sched;
    localparam int unsigned MD_LATENCY = 4;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned PERF_W     = 4;
    localparam int unsigned SAT        = (1 << PERF_W) - 1;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    pipe_hazard_sched_if #(.PERF_W(PERF_W)) bus ();

    pipe_hazard_sched #(
        .MD_LATENCY(MD_LATENCY),
        .CNT_W     (CNT_W),
        .PERF_W    (PERF_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: cycles of mul/div stall still owed, sticky error, stall count.
    int md_left;
    bit m_err;
    int m_stall;

    initial begin
        md_left = 0;
        m_err   = 1'b0;
        m_stall = 0;
    end

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        bit e_pc, e_ifid, e_ifl, e_idf, e_busy, e_done, hazard;
        bit br;
        br     = bus.branch_taken;
        hazard = bus.ex_memread && bus.ex_regwrite && bus.ex_rw != 0 &&
                 ((bus.id_uses_rs && bus.id_rs == bus.ex_rw) ||
                  (bus.id_uses_rt && bus.id_rt == bus.ex_rw));
        {e_pc, e_ifid, e_ifl, e_idf, e_busy, e_done} = 6'b110000;
        cmp("stall_cycles", int'(bus.stall_cycles), m_stall);
        cmp("protocol_err", int'(bus.protocol_err), int'(m_err));
        if (rst) begin
            {e_pc, e_ifid, e_ifl, e_idf} = 4'b0011;
        end else if (md_left > 0) begin
            {e_pc, e_ifid, e_idf, e_busy} = 4'b0011;
            e_done = (md_left == 1);
        end else if (br) begin
            {e_ifl, e_idf} = 2'b11;
        end else if (hazard) begin
            {e_pc, e_ifid, e_idf} = 3'b001;
        end
        cmp("pc_en",      int'(bus.pc_en),      int'(e_pc));
        cmp("ifid_en",    int'(bus.ifid_en),    int'(e_ifid));
        cmp("ifid_flush", int'(bus.ifid_flush), int'(e_ifl));
        cmp("idex_flush", int'(bus.idex_flush), int'(e_idf));
        cmp("md_busy",    int'(bus.md_busy),    int'(e_busy));
        cmp("md_done",    int'(bus.md_done),    int'(e_done));
        if (rst) begin
            md_left = 0;
            m_err   = 1'b0;
            m_stall = 0;
        end else begin
            if (md_left > 0) begin
                if (br) m_err = 1'b1;
                md_left--;
            end else if (!br && !hazard && bus.id_md_start) begin
                md_left = MD_LATENCY - 1;
            end
            if (!e_pc && m_stall < SAT) m_stall++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.id_rs        = 5'd0;
        bus.id_rt        = 5'd0;
        bus.id_uses_rs   = 1'b0;
        bus.id_uses_rt   = 1'b0;
        bus.id_md_start  = 1'b0;
        bus.ex_memread   = 1'b0;
        bus.ex_regwrite  = 1'b0;
        bus.ex_rw        = 5'd0;
        bus.branch_taken = 1'b0;
    endtask

    task automatic do_reset();
        clr();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic load_use(input logic [4:0] rw, input logic [4:0] rs, input logic [4:0] rt);
        bus.ex_memread  = 1'b1;
        bus.ex_regwrite = 1'b1;
        bus.ex_rw       = rw;
        bus.id_rs       = rs;
        bus.id_rt       = rt;
        bus.id_uses_rs  = 1'b1;
        bus.id_uses_rt  = 1'b1;
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        clr();
        tick();
        cmp("rst_pc_en", int'(bus.pc_en), 0);
        cmp("rst_ifid_flush", int'(bus.ifid_flush), 1);
        cmp("rst_idex_flush", int'(bus.idex_flush), 1);
        do_reset();

        // lw r5 in EX, ID reads r5: one bubble
        load_use(5'd5, 5'd5, 5'd7);
        cmp("lu_pc_en", int'(bus.pc_en), 0);
        cmp("lu_idex_flush", int'(bus.idex_flush), 1);
        tick();
        clr();
        #1;
        cmp("lu_after_pc_en", int'(bus.pc_en), 1);
        cmp("lu_stall_cycles", int'(bus.stall_cycles), 1);

        // match via rt only
        load_use(5'd9, 5'd3, 5'd9);
        cmp("lu_rt_pc_en", int'(bus.pc_en), 0);
        tick();
        clr();

        // r0 exemption
        load_use(5'd0, 5'd0, 5'd0);
        cmp("r0_pc_en", int'(bus.pc_en), 1);
        tick();
        clr();
        #1;
        cmp("r0_stall_cycles", int'(bus.stall_cycles), 2);

        // mul/div: accept cycle normal, then 3 stall cycles, md_done on the 3rd
        do_reset();
        bus.id_md_start = 1'b1;
        #1;
        cmp("md_accept_pc_en", int'(bus.pc_en), 1);
        tick();
        clr();
        #1;
        cmp("md_w1_busy", int'(bus.md_busy), 1);
        cmp("md_w1_done", int'(bus.md_done), 0);
        tick();
        tick();
        cmp("md_w3_done", int'(bus.md_done), 1);
        cmp("md_w3_pc_en", int'(bus.pc_en), 0);
        // back-to-back mul/div accepted right after md_done
        bus.id_md_start = 1'b1;
        tick();
        cmp("md_run_stall_cycles", int'(bus.stall_cycles), 3);
        cmp("md2_accept_pc_en", int'(bus.pc_en), 1);
        tick();
        clr();
        #1;
        cmp("md2_busy", int'(bus.md_busy), 1);
        tick();
        tick();
        tick();
        cmp("md2_idle_busy", int'(bus.md_busy), 0);
        cmp("md2_stall_cycles", int'(bus.stall_cycles), 6);

        // branch wins over load-use and md start
        do_reset();
        load_use(5'd4, 5'd4, 5'd4);
        bus.id_md_start  = 1'b1;
        bus.branch_taken = 1'b1;
        #1;
        cmp("br_pc_en", int'(bus.pc_en), 1);
        cmp("br_ifid_flush", int'(bus.ifid_flush), 1);
        cmp("br_idex_flush", int'(bus.idex_flush), 1);
        tick();
        clr();
        #1;
        cmp("br_no_md_busy", int'(bus.md_busy), 0);
        cmp("br_stall_cycles", int'(bus.stall_cycles), 0);

        // branch during MD_WAIT: sticky error, sequence unchanged
        bus.id_md_start = 1'b1;
        tick();
        clr();
        bus.branch_taken = 1'b1;
        #1;
        cmp("mdbr_busy", int'(bus.md_busy), 1);
        tick();
        clr();
        #1;
        cmp("mdbr_perr", int'(bus.protocol_err), 1);
        tick();
        cmp("mdbr_done", int'(bus.md_done), 1);
        tick();
        tick();
        cmp("mdbr_perr_sticky", int'(bus.protocol_err), 1);
        cmp("mdbr_stall_cycles", int'(bus.stall_cycles), 3);

        // reset in 2nd MD_WAIT cycle
        do_reset();
        bus.id_md_start = 1'b1;
        tick();
        clr();
        tick();
        rst = 1'b1;
        #1;
        cmp("mdrst_no_done", int'(bus.md_done), 0);
        tick();
        rst = 1'b0;
        #1;
        cmp("mdrst_busy", int'(bus.md_busy), 0);
        cmp("mdrst_stall_cycles", int'(bus.stall_cycles), 0);
        cmp("mdrst_pc_en", int'(bus.pc_en), 1);

        // saturation of the stall counter
        load_use(5'd2, 5'd2, 5'd0);
        repeat (SAT + 4) tick();
        cmp("sat_stall_cycles", int'(bus.stall_cycles), int'(SAT));
        clr();
        tick();

        // mixed traffic against the model
        do_reset();
        for (int i = 0; i < 300; i++) begin
            bus.id_rs        = 5'($urandom_range(0, 3));
            bus.id_rt        = 5'($urandom_range(0, 3));
            bus.id_uses_rs   = 1'($urandom);
            bus.id_uses_rt   = 1'($urandom);
            bus.ex_memread   = 1'($urandom);
            bus.ex_regwrite  = 1'($urandom);
            bus.ex_rw        = 5'($urandom_range(0, 3));
            bus.id_md_start  = ($urandom_range(0, 5) == 0);
            bus.branch_taken = ($urandom_range(0, 7) == 0);
            rst              = ($urandom_range(0, 39) == 0);
            tick();
        end
        rst = 1'b0;
        clr();
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
